// File: rtl/mem_arb2.sv
// Two-master round-robin arbiter onto one memory port, with an in-order
// read-tag FIFO that routes read returns back to the issuing master.
// Ports: clk/rst_n (sync, active-low), arb_ena, per-master m{0,1}_req/
//   write/addr/wdata -> m{0,1}_gnt, m{0,1}_rdata_vld/rdata; shared
//   mem_req/write/addr/wdata/rdata_vld/rdata; rd_outstanding, err_underflow.
module mem_arb2 #(
  parameter int MEM_AW    = 16,
  parameter int MEM_DW    = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arb_ena,
  input  logic                         m0_req,
  input  logic                         m0_write,
  input  logic [MEM_AW-1:0]            m0_addr,
  input  logic [MEM_DW-1:0]            m0_wdata,
  input  logic                         m1_req,
  input  logic                         m1_write,
  input  logic [MEM_AW-1:0]            m1_addr,
  input  logic [MEM_DW-1:0]            m1_wdata,
  output logic                         m0_gnt,
  output logic                         m1_gnt,
  output logic                         m0_rdata_vld,
  output logic                         m1_rdata_vld,
  output logic [MEM_DW-1:0]            m0_rdata,
  output logic [MEM_DW-1:0]            m1_rdata,
  output logic                         mem_req,
  output logic                         mem_write,
  output logic [MEM_AW-1:0]            mem_addr,
  output logic [MEM_DW-1:0]            mem_wdata,
  input  logic                         mem_rdata_vld,
  input  logic [MEM_DW-1:0]            mem_rdata,
  output logic [$clog2(OUT_DEPTH):0]   rd_outstanding,
  output logic                         err_underflow
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;

  logic                 rr_q, rr_d;
  logic [PW-1:0]        wp_q, wp_d;
  logic [PW-1:0]        rp_q, rp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [OUT_DEPTH-1:0] tag_q, tag_d;

  logic rd_room;
  logic el0, el1;
  logic push, pop, head;

  // Room check uses the registered count only: a same-cycle return
  // never frees a slot for a same-cycle read grant.
  assign rd_room = (cnt_q < CW'(OUT_DEPTH));

  // rst_n gating keeps grants and returns quiet while in reset.
  assign el0 = rst_n & arb_ena & m0_req & (m0_write | rd_room);
  assign el1 = rst_n & arb_ena & m1_req & (m1_write | rd_room);

  // A lone eligible master wins regardless of rr.
  assign m0_gnt = el0 & (~el1 | ~rr_q);
  assign m1_gnt = el1 & (~el0 |  rr_q);

  always_comb begin
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      m0_gnt: begin
        mem_req   = 1'b1;
        mem_write = m0_write;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
      end
      m1_gnt: begin
        mem_req   = 1'b1;
        mem_write = m1_write;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  assign push = mem_req & ~mem_write;
  assign pop  = rst_n & mem_rdata_vld & (cnt_q != '0);
  assign head = tag_q[rp_q];

  assign m0_rdata_vld = pop & ~head;
  assign m1_rdata_vld = pop &  head;
  assign m0_rdata     = mem_rdata;
  assign m1_rdata     = mem_rdata;

  assign rd_outstanding = cnt_q;
  assign err_underflow  = err_q;

  always_comb begin
    rr_d  = rr_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    tag_d = tag_q;
    err_d = err_q;
    if (mem_req) rr_d = m0_gnt;
    if (push) begin
      tag_d[wp_q] = m1_gnt;
      wp_d        = wp_q + PW'(1);
    end
    if (pop) rp_d = rp_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (mem_rdata_vld && cnt_q == '0) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q  <= 1'b0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      tag_q <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: memory model with in-order returns, scoreboard of
// expected read returns per master, scenario tasks with inline checks.
module tb_mem_arb2;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arb_ena = 1'b1;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic          m0_write = 1'b0, m1_write = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt;
  logic          m0_rdata_vld, m1_rdata_vld;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_req, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rdata_vld = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    rd_outstanding;
  logic          err_underflow;

  mem_arb2 #(.MEM_AW(AW), .MEM_DW(DW), .OUT_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .arb_ena(arb_ena),
    .m0_req(m0_req), .m0_write(m0_write),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_write(m1_write),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rdata_vld(m0_rdata_vld), .m1_rdata_vld(m1_rdata_vld),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata),
    .rd_outstanding(rd_outstanding),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic id; logic [DW-1:0] data; } exp_t;
  typedef struct { logic [AW-1:0] addr; int due; } mq_t;

  exp_t sb[$];
  mq_t  memq[$];
  exp_t e_m;
  mq_t  m_d;

  int vec = 0;
  int err = 0;
  int cyc = 0;
  int rx0 = 0, rx1 = 0;
  int mem_lat = 3;
  bit mem_hold = 1'b0;
  bit stray = 1'b0;

  function automatic logic [DW-1:0] mdat(input logic [AW-1:0] a);
    return {a ^ 16'ha5a5, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: returns reads in order, no earlier than mem_lat cycles.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (stray) begin
      mem_rdata_vld = 1'b1;
      mem_rdata     = 32'hdeadbeef;
    end else if (!mem_hold && memq.size() > 0 && memq[0].due <= cyc) begin
      m_d = memq.pop_front();
      mem_rdata_vld = 1'b1;
      mem_rdata     = mdat(m_d.addr);
    end else begin
      mem_rdata_vld = 1'b0;
      mem_rdata     = $urandom;
    end
  end

  // Scoreboard monitor: routing of returns, grant muxing, outstanding count.
  always @(negedge clk) begin
    if (!rst_n) begin
      vec++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_req !== 1'b0 ||
          m0_rdata_vld !== 1'b0 || m1_rdata_vld !== 1'b0) begin
        err++;
        $display("FAIL rst_quiet gnt=%b%b req=%b vld=%b%b want all 0",
                 m0_gnt, m1_gnt, mem_req, m0_rdata_vld, m1_rdata_vld);
      end
      sb.delete();
      memq.delete();
    end else begin
      vec++;
      if (rd_outstanding !== 3'(sb.size())) begin
        err++;
        $display("FAIL outstanding got=%0d want=%0d",
                 rd_outstanding, sb.size());
      end
      vec++;
      if (mem_rdata_vld && sb.size() > 0) begin
        e_m = sb.pop_front();
        if (e_m.id) begin
          rx1++;
          if (m1_rdata_vld !== 1'b1 || m0_rdata_vld !== 1'b0 ||
              m1_rdata !== e_m.data) begin
            err++;
            $display("FAIL ret_m1 vld=%b%b data=%h want vld=01 data=%h",
                     m0_rdata_vld, m1_rdata_vld, m1_rdata, e_m.data);
          end
        end else begin
          rx0++;
          if (m0_rdata_vld !== 1'b1 || m1_rdata_vld !== 1'b0 ||
              m0_rdata !== e_m.data) begin
            err++;
            $display("FAIL ret_m0 vld=%b%b data=%h want vld=10 data=%h",
                     m0_rdata_vld, m1_rdata_vld, m0_rdata, e_m.data);
          end
        end
      end else if (m0_rdata_vld !== 1'b0 || m1_rdata_vld !== 1'b0) begin
        err++;
        $display("FAIL ret_none vld=%b%b want 00",
                 m0_rdata_vld, m1_rdata_vld);
      end
      vec++;
      if (m0_gnt === 1'b1 && m1_gnt === 1'b1) begin
        err++;
        $display("FAIL gnt_onehot gnt=11 want at most one");
      end else if (m0_gnt === 1'b1) begin
        if (mem_req !== 1'b1 || mem_write !== m0_write ||
            mem_addr !== m0_addr || mem_wdata !== m0_wdata) begin
          err++;
          $display("FAIL mux_m0 req=%b wr=%b addr=%h want 1 %b %h",
                   mem_req, mem_write, mem_addr, m0_write, m0_addr);
        end
        if (!m0_write) begin
          sb.push_back('{1'b0, mdat(m0_addr)});
          memq.push_back('{m0_addr, cyc + mem_lat});
        end
      end else if (m1_gnt === 1'b1) begin
        if (mem_req !== 1'b1 || mem_write !== m1_write ||
            mem_addr !== m1_addr || mem_wdata !== m1_wdata) begin
          err++;
          $display("FAIL mux_m1 req=%b wr=%b addr=%h want 1 %b %h",
                   mem_req, mem_write, mem_addr, m1_write, m1_addr);
        end
        if (!m1_write) begin
          sb.push_back('{1'b1, mdat(m1_addr)});
          memq.push_back('{m1_addr, cyc + mem_lat});
        end
      end else if (mem_req !== 1'b0 || mem_write !== 1'b0 ||
                   mem_addr !== '0 || mem_wdata !== '0) begin
        err++;
        $display("FAIL mux_idle req=%b wr=%b addr=%h wd=%h want zeros",
                 mem_req, mem_write, mem_addr, mem_wdata);
      end
    end
  end

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    mem_hold = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && memq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_req = 1'b1;
    m1_req = 1'b1;
    stray = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    vec++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_req !== 1'b0) begin
      err++;
      $display("FAIL reset_gnt gnt=%b%b req=%b want 000",
               m0_gnt, m1_gnt, mem_req);
    end
    tick();
    rst_n = 1'b1;
    stray = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    vec++;
    if (rd_outstanding !== 3'd0 || err_underflow !== 1'b0) begin
      err++;
      $display("FAIL reset_state out=%0d err=%b want 0 0",
               rd_outstanding, err_underflow);
    end
    tick();
  endtask

  task automatic test_rr_reads();
    int a0 = 0, a1 = 0;
    int r0 = rx0, r1 = rx1;
    bit ok;
    logic exp1 = 1'b0;
    logic g0, g1;
    mem_lat = 3;
    m0_write = 1'b0;
    m1_write = 1'b0;
    m0_addr = 16'h100;
    m1_addr = 16'h200;
    m0_req = 1'b1;
    m1_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      g0 = m0_gnt;
      g1 = m1_gnt;
      vec++;
      if (g0 !== ~exp1 || g1 !== exp1) begin
        err++;
        $display("FAIL rr_alt cyc%0d gnt=%b%b want %b%b",
                 i, g0, g1, ~exp1, exp1);
      end
      exp1 = ~exp1;
      tick();
      if (g0 === 1'b1) begin
        a0++;
        m0_addr = 16'(32'h100 + a0);
      end
      if (g1 === 1'b1) begin
        a1++;
        m1_addr = 16'(32'h200 + a1);
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    wait_drain(ok);
    vec++;
    if (!ok || rx0 - r0 != 10 || rx1 - r1 != 10) begin
      err++;
      $display("FAIL rr_rx drained=%b rx0=%0d rx1=%0d want 1 10 10",
               ok, rx0 - r0, rx1 - r1);
    end
  endtask

  task automatic test_writes();
    m1_write = 1'b1;
    m1_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      m1_addr = 16'(32'h300 + k);
      m1_wdata = $urandom;
      @(negedge clk);
      vec++;
      if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 ||
          mem_addr !== 16'(32'h300 + k) || rd_outstanding !== 3'd0) begin
        err++;
        $display("FAIL wr_burst k=%0d gnt=%b%b addr=%h out=%0d want 01 %h 0",
                 k, m0_gnt, m1_gnt, mem_addr, rd_outstanding,
                 16'(32'h300 + k));
      end
      tick();
    end
    m1_req = 1'b0;
    m1_write = 1'b0;
  endtask

  task automatic test_full_stall();
    bit ok;
    bit got = 1'b0;
    mem_hold = 1'b1;
    m0_write = 1'b0;
    m0_addr = 16'h400;
    m0_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec++;
      if (m0_gnt !== 1'b1) begin
        err++;
        $display("FAIL stall_fill i=%0d gnt=%b want 1", i, m0_gnt);
      end
      tick();
      m0_addr = m0_addr + 16'd1;
    end
    m1_req = 1'b1;
    m1_write = 1'b1;
    m1_addr = 16'h500;
    m1_wdata = 32'h1234_5678;
    @(negedge clk);
    vec++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1 || rd_outstanding !== 3'd4) begin
      err++;
      $display("FAIL stall_wr gnt=%b%b out=%0d want 01 4",
               m0_gnt, m1_gnt, rd_outstanding);
    end
    tick();
    m1_req = 1'b0;
    m1_write = 1'b0;
    @(negedge clk);
    vec++;
    if (m0_gnt !== 1'b0 || rd_outstanding !== 3'd4) begin
      err++;
      $display("FAIL stall_hold gnt=%b out=%0d want 0 4",
               m0_gnt, rd_outstanding);
    end
    tick();
    mem_hold = 1'b0;
    @(negedge clk);
    vec++;
    if (m0_gnt !== 1'b0 || m0_rdata_vld !== 1'b1 ||
        rd_outstanding !== 3'd4) begin
      err++;
      $display("FAIL stall_nobypass gnt=%b vld=%b out=%0d want 0 1 4",
               m0_gnt, m0_rdata_vld, rd_outstanding);
    end
    tick();
    mem_hold = 1'b1;
    @(negedge clk);
    vec++;
    if (m0_gnt !== 1'b1 || rd_outstanding !== 3'd3) begin
      err++;
      $display("FAIL stall_reopen gnt=%b out=%0d want 1 3",
               m0_gnt, rd_outstanding);
    end
    tick();
    m0_addr = m0_addr + 16'd1;
    @(negedge clk);
    vec++;
    if (m0_gnt !== 1'b0 || rd_outstanding !== 3'd4) begin
      err++;
      $display("FAIL stall_refull gnt=%b out=%0d want 0 4",
               m0_gnt, rd_outstanding);
    end
    tick();
    mem_hold = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = (m0_gnt === 1'b1);
      tick();
    end
    m0_req = 1'b0;
    wait_drain(ok);
    vec++;
    if (!got || !ok) begin
      err++;
      $display("FAIL stall_sixth granted=%b drained=%b want 1 1", got, ok);
    end
  endtask

  task automatic test_arb_ena();
    int g = 0;
    int r = 0;
    logic d0, d1;
    mem_hold = 1'b1;
    m0_write = 1'b0;
    m1_write = 1'b0;
    m0_addr = 16'h600;
    m1_addr = 16'h700;
    m0_req = 1'b1;
    m1_req = 1'b1;
    for (int i = 0; i < 6 && g < 2; i++) begin
      @(negedge clk);
      d0 = m0_gnt;
      d1 = m1_gnt;
      if (d0 === 1'b1) g++;
      if (d1 === 1'b1) g++;
      tick();
      if (d0 === 1'b1) m0_req = 1'b0;
      if (d1 === 1'b1) m1_req = 1'b0;
    end
    arb_ena = 1'b0;
    m0_req = 1'b1;
    m1_req = 1'b1;
    r = rx0 + rx1;
    @(negedge clk);
    vec++;
    if (g != 2 || rd_outstanding !== 3'd2) begin
      err++;
      $display("FAIL ena_setup grants=%0d out=%0d want 2 2",
               g, rd_outstanding);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) mem_hold = 1'b0;
      @(negedge clk);
      vec++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
        err++;
        $display("FAIL ena_block i=%0d gnt=%b%b want 00",
                 i, m0_gnt, m1_gnt);
      end
      tick();
    end
    @(negedge clk);
    vec++;
    if (rx0 + rx1 - r != 2 || rd_outstanding !== 3'd0) begin
      err++;
      $display("FAIL ena_returns rx=%0d out=%0d want 2 0",
               rx0 + rx1 - r, rd_outstanding);
    end
    tick();
    arb_ena = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic test_underflow();
    bit ok;
    wait_drain(ok);
    @(negedge clk);
    vec++;
    if (!ok || rd_outstanding !== 3'd0 || err_underflow !== 1'b0) begin
      err++;
      $display("FAIL uf_pre drained=%b out=%0d err=%b want 1 0 0",
               ok, rd_outstanding, err_underflow);
    end
    tick();
    stray = 1'b1;
    @(negedge clk);
    vec++;
    if (m0_rdata_vld !== 1'b0 || m1_rdata_vld !== 1'b0) begin
      err++;
      $display("FAIL uf_route vld=%b%b want 00", m0_rdata_vld, m1_rdata_vld);
    end
    tick();
    stray = 1'b0;
    @(negedge clk);
    vec++;
    if (err_underflow !== 1'b1 || rd_outstanding !== 3'd0) begin
      err++;
      $display("FAIL uf_set err=%b out=%0d want 1 0",
               err_underflow, rd_outstanding);
    end
    repeat (5) tick();
    @(negedge clk);
    vec++;
    if (err_underflow !== 1'b1) begin
      err++;
      $display("FAIL uf_sticky err=%b want 1", err_underflow);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit got = 1'b0;
    mem_hold = 1'b1;
    m0_write = 1'b0;
    m0_addr = 16'h800;
    m0_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++;
      if (m0_gnt !== 1'b1) begin
        err++;
        $display("FAIL rm_issue i=%0d gnt=%b want 1", i, m0_gnt);
      end
      tick();
      m0_addr = m0_addr + 16'd1;
    end
    m0_req = 1'b0;
    @(negedge clk);
    vec++;
    if (rd_outstanding !== 3'd3) begin
      err++;
      $display("FAIL rm_out got=%0d want 3", rd_outstanding);
    end
    tick();
    rst_n = 1'b0;
    m0_req = 1'b1;
    m1_req = 1'b1;
    m1_write = 1'b0;
    m0_addr = 16'h900;
    m1_addr = 16'ha00;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    mem_hold = 1'b0;
    @(negedge clk);
    vec++;
    if (rd_outstanding !== 3'd0 || err_underflow !== 1'b0 ||
        m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      err++;
      $display("FAIL rm_after out=%0d err=%b gnt=%b%b want 0 0 10",
               rd_outstanding, err_underflow, m0_gnt, m1_gnt);
    end
    tick();
    m0_req = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      got = (m1_gnt === 1'b1);
      tick();
    end
    m1_req = 1'b0;
    wait_drain(ok);
    vec++;
    if (!got || !ok) begin
      err++;
      $display("FAIL rm_drain m1_granted=%b drained=%b want 1 1", got, ok);
    end
  endtask

  initial begin
    test_reset();
    test_rr_reads();
    test_writes();
    test_full_stall();
    test_arb_ena();
    test_underflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arb2.md
MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 SHALL have parameter MEM_AW, default 16, memory address width.
REQ-002 SHALL have parameter MEM_DW, default 32, memory data width.
REQ-003 SHALL have parameter OUT_DEPTH, default 4, maximum outstanding reads (power of 2, >=2).
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port arb_ena  in  1  grant enable; low freezes new grants.
REQ-007 SHALL have ports m0_req, m1_req  in  1  requester access request, held until granted.
REQ-008 SHALL have ports m0_write, m1_write  in  1  1=write, 0=read; stable while req high.
REQ-009 SHALL have ports m0_addr, m1_addr  in  MEM_AW  access address.
REQ-010 SHALL have ports m0_wdata, m1_wdata  in  MEM_DW  write data.
REQ-011 SHALL have ports m0_gnt, m1_gnt  out  1  request accepted this cycle.
REQ-012 SHALL have ports m0_rdata_vld, m1_rdata_vld  out  1  read data valid for that requester.
REQ-013 SHALL have ports m0_rdata, m1_rdata  out  MEM_DW  read data (copy of mem_rdata).
REQ-014 SHALL have ports mem_req, mem_write  out  1  shared memory request / write strobe.
REQ-015 SHALL have port mem_addr  out  MEM_AW  shared memory address.
REQ-016 SHALL have port mem_wdata  out  MEM_DW  shared memory write data.
REQ-017 SHALL have port mem_rdata_vld  in  1  memory read return valid; returns in request order, latency >=1.
REQ-018 SHALL have port mem_rdata  in  MEM_DW  memory read data.
REQ-019 SHALL have port rd_outstanding  out  $clog2(OUT_DEPTH)+1  count of issued, unreturned reads.
REQ-020 SHALL have port err_underflow  out  1  sticky: return seen with zero outstanding.

Function
REQ-021 Requester i SHALL be eligible when mi_req=1, arb_ena=1, and (mi_write=1 or rd_outstanding<OUT_DEPTH).
REQ-022 Grant SHALL be combinational in the same cycle: at most one mi_gnt high, only to an eligible requester.
REQ-023 Arbitration SHALL be round-robin: priority pointer rr (reset 0) favours requester rr; after a grant to i, rr <= 1-i.
REQ-024 With one eligible requester, it SHALL be granted every cycle regardless of rr (no idle bubbles).
REQ-025 mem_req SHALL equal OR of mi_gnt; mem_write/mem_addr/mem_wdata SHALL be muxed from the granted requester, and SHALL be 0 when no grant.
REQ-026 Each granted read SHALL push its requester id into an OUT_DEPTH-entry in-order tag FIFO.
REQ-027 On mem_rdata_vld=1 with FIFO non-empty, the head id SHALL be popped and mi_rdata_vld asserted combinationally for that id only, same cycle.
REQ-028 mi_rdata SHALL always equal mem_rdata (qualification by mi_rdata_vld only).
REQ-029 Simultaneous read grant and return SHALL push and pop in the same cycle; rd_outstanding unchanged; a full FIFO with same-cycle return SHALL still block the read grant (no bypass).
REQ-030 mem_rdata_vld with FIFO empty SHALL set err_underflow, assert no mi_rdata_vld, leave the FIFO unchanged.
REQ-031 Writes SHALL NOT enter the FIFO and SHALL be grantable while the FIFO is full.
REQ-032 arb_ena=0 SHALL block grants only; returns SHALL still be routed.
REQ-033 FIFO pointers SHALL wrap modulo OUT_DEPTH; rd_outstanding SHALL range 0..OUT_DEPTH.

Reset
REQ-034 While rst_n=0 at a rising edge: rr=0, FIFO empty, rd_outstanding=0, err_underflow=0.
REQ-035 During reset all mi_gnt, mi_rdata_vld, mem_req SHALL be 0 regardless of inputs.
REQ-036 Reset mid-operation SHALL discard outstanding tags; later stray returns SHALL set err_underflow after reset.

Verification
REQ-037 Both requesters reading continuously, memory latency 3 -> grants alternate m0,m1,m0,...; each requester receives exactly its own data in order; no mi_rdata_vld to wrong port.
REQ-038 Only m1 requesting 8 writes to addr 'h300..'h307 -> m1_gnt high 8 consecutive cycles; mem_addr matches; rd_outstanding stays 0.
REQ-039 OUT_DEPTH=4, memory withholds returns, m0 issues 6 reads -> 4 grants, m0_gnt low with rd_outstanding=4; m1 write during stall granted; first return re-enables m0 the next cycle (count 3 -> 4).
REQ-040 arb_ena=0 for 20 cycles with 2 reads outstanding -> no grants; both returns delivered; rd_outstanding 2 -> 0.
REQ-041 mem_rdata_vld pulse with rd_outstanding=0 -> err_underflow=1 and held until rst_n=0.
REQ-042 rst_n=0 one cycle with 3 reads outstanding -> rd_outstanding=0, rr=0; next cycle with both requesting, m0 granted first.
